batch_pipeline_unit: RTL and testbench

//  Parametrised successor of the fixed 4-stage batch functional unit.
//  - Carries decoded instruction batches through PIPELINE_STAGES registered stages.
//  - Adds per-stage valid bits with valid/ready backpressure and bubble collapsing,

---
 rtl/fu_pkg.sv | 39 +++
 rtl/pipe_stage_reg.sv | 38 +++
 rtl/batch_pipeline_unit.sv | 118 +++++++++++
 tb/tb_batch_pipeline_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared types and constants for the batch functional unit: batch layout,
// stage payload record and the batch-to-payload unpacking helper.
package fu_pkg;

    localparam int INSTRUCTION_WIDTH       = 16;
    localparam int FORMAT_WIDTH            = 3;
    localparam int BATCH_INSTRUCTION_WIDTH = 4;
    localparam int METADATA_WIDTH          = 16;
    localparam int BATCH_WIDTH             = METADATA_WIDTH + BATCH_INSTRUCTION_WIDTH * INSTRUCTION_WIDTH;

    typedef enum int {
        DECODE    = 0,
        EXECUTE   = 1,
        MEMORY    = 2,
        WRITEBACK = 3
    } stage_index_e;

    typedef struct packed {
        logic [BATCH_INSTRUCTION_WIDTH-1:0][INSTRUCTION_WIDTH-1:0] instr;
        logic [BATCH_INSTRUCTION_WIDTH-1:0][FORMAT_WIDTH-1:0]      fmt;
        logic                                                      endTag;
    } stage_payload_t;

    // Bit 0 and the metadata bits above the format fields carry nothing the pipe needs.
    function automatic stage_payload_t unpack_batch(input logic [BATCH_WIDTH-1:0] batch,
                                                    input logic                   endTag);
        stage_payload_t payload;
        logic           unusedMeta;
        payload    = '0;
        unusedMeta = ^{batch[METADATA_WIDTH-1:1+BATCH_INSTRUCTION_WIDTH*FORMAT_WIDTH], batch[0]};
        for (int i = 0; i < BATCH_INSTRUCTION_WIDTH; i++) begin
            payload.fmt[i]   = batch[1 + i*FORMAT_WIDTH +: FORMAT_WIDTH];
            payload.instr[i] = batch[METADATA_WIDTH + i*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
        end
        payload.endTag = endTag;
        return payload;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: a valid bit plus the batch payload it carries.
// Flush wins over load, load wins over advancing out.
module pipe_stage_reg
    import fu_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           flush,
    input  logic           load,
    input  logic           advance,
    input  stage_payload_t loadPayload,
    output logic           valid,
    output stage_payload_t payload
);

    // NOTE: non-blocking assignments so every stage samples pre-edge values and the pipe shifts as one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (advance) begin
            valid <= 1'b0;
        end
    end

    // NOTE: payload is plain flops, not a RAM, so it is cleared on reset to keep outputs deterministic.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            payload <= '0;
        end else if (load) begin
            payload <= loadPayload;
        end
    end

endmodule

// File: rtl/batch_pipeline_unit.sv
// Parametrised batch pipe with valid/ready backpressure, bubble collapsing,
// synchronous flush and end-tag group counting on retirement.
module batch_pipeline_unit
    import fu_pkg::*;
#(
    parameter int PIPELINE_STAGES = 4,
    parameter int LANES           = BATCH_INSTRUCTION_WIDTH,
    parameter int INSTR_W         = INSTRUCTION_WIDTH,
    parameter int FMT_W           = FORMAT_WIDTH,
    parameter int META_W          = METADATA_WIDTH,
    parameter int BATCH_W         = BATCH_WIDTH,
    parameter int CNT_W           = 16,
    localparam int OCC_W          = $clog2(PIPELINE_STAGES + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [BATCH_W-1:0]       batch,
    input  logic                     endTag,
    input  logic                     flush,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [LANES*INSTR_W-1:0] outInstr,
    output logic [LANES*FMT_W-1:0]   outFmt,
    output logic                     outEndTag,
    output logic                     doneBatches,
    output logic [CNT_W-1:0]         groupSize,
    output logic [OCC_W-1:0]         occupancy
);

    localparam int LAST = PIPELINE_STAGES - 1;

    logic [PIPELINE_STAGES-1:0] stageValid;
    logic [PIPELINE_STAGES-1:0] stageLoad;
    logic [PIPELINE_STAGES-1:0] adv;
    stage_payload_t             stagePayload [PIPELINE_STAGES];
    stage_payload_t             inPayload;
    logic                       accept;
    logic                       retire;
    logic                       downstreamOpen;
    logic [CNT_W-1:0]           groupCount;
    logic                       unusedMeta;

    assign inPayload  = unpack_batch(batch, endTag);
    assign unusedMeta = ^{batch[META_W-1:1+LANES*FMT_W], batch[0]};

    // Walk from the output back: a stage may move when the one ahead is empty or moving too.
    // NOTE: every always_comb output gets a default before any branch or loop, so no latches are inferred.
    always_comb begin
        retire         = stageValid[LAST] && !flush && outReady;
        adv            = '0;
        adv[LAST]      = retire;
        downstreamOpen = !stageValid[LAST] || retire;
        for (int k = LAST - 1; k >= 0; k--) begin
            adv[k]         = stageValid[k] && downstreamOpen;
            downstreamOpen = !stageValid[k] || adv[k];
        end
        inReady   = !flush && downstreamOpen;
        accept    = inValid && inReady;
        stageLoad = {adv[LAST-1:0], accept};
    end

    for (genvar k = 0; k < PIPELINE_STAGES; k++) begin : gStage
        stage_payload_t feed;
        if (k == 0) begin : gFirst
            assign feed = inPayload;
        end else begin : gNext
            assign feed = stagePayload[k-1];
        end

        pipe_stage_reg uStage (
            .clock      (clock),
            .reset      (reset),
            .flush      (flush),
            .load       (stageLoad[k]),
            .advance    (adv[k]),
            .loadPayload(feed),
            .valid      (stageValid[k]),
            .payload    (stagePayload[k])
        );
    end

    assign outValid  = stageValid[LAST] && !flush;
    assign outInstr  = stagePayload[LAST].instr;
    assign outFmt    = stagePayload[LAST].fmt;
    assign outEndTag = stagePayload[LAST].endTag;

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < PIPELINE_STAGES; k++) begin
            occupancy = occupancy + OCC_W'(stageValid[k]);
        end
    end

    // groupSize survives a flush; only the partial count of the discarded group is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            groupCount  <= '0;
            groupSize   <= '0;
            doneBatches <= 1'b0;
        end else if (flush) begin
            groupCount  <= '0;
            doneBatches <= 1'b0;
        end else begin
            doneBatches <= retire && outEndTag;
            if (retire) begin
                if (outEndTag) begin
                    groupSize  <= groupCount + CNT_W'(1);
                    groupCount <= '0;
                end else begin
                    groupCount <= groupCount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_batch_pipeline_unit.sv
// Self-checking bench: a per-cycle vector table for streaming and stall,
// hand-written sequences for reset, bubbles, flush and depth variants.
module tb_batch_pipeline_unit;
    import fu_pkg::*;

    logic                   clock;
    logic                   reset;
    logic                   inValid;
    logic [BATCH_WIDTH-1:0] batch;
    logic                   endTag;
    logic                   flush;
    logic                   outReady;

    logic        inReady,  outValid,  outEndTag,  doneBatches;
    logic [63:0] outInstr;
    logic [11:0] outFmt;
    logic [15:0] groupSize;
    logic [2:0]  occupancy;

    logic        inReady2, outValid2, outEndTag2, doneBatches2;
    logic [63:0] outInstr2;
    logic [11:0] outFmt2;
    logic [15:0] groupSize2;
    logic [1:0]  occupancy2;

    logic        inReady7, outValid7, outEndTag7, doneBatches7;
    logic [63:0] outInstr7;
    logic [11:0] outFmt7;
    logic [15:0] groupSize7;
    logic [2:0]  occupancy7;

    int checks = 0;
    int errors = 0;

    batch_pipeline_unit #(.PIPELINE_STAGES(4)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady), .batch(batch),
        .endTag(endTag), .flush(flush), .outValid(outValid), .outReady(outReady),
        .outInstr(outInstr), .outFmt(outFmt), .outEndTag(outEndTag), .doneBatches(doneBatches),
        .groupSize(groupSize), .occupancy(occupancy)
    );

    batch_pipeline_unit #(.PIPELINE_STAGES(2)) dut2 (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady2), .batch(batch),
        .endTag(endTag), .flush(flush), .outValid(outValid2), .outReady(outReady),
        .outInstr(outInstr2), .outFmt(outFmt2), .outEndTag(outEndTag2), .doneBatches(doneBatches2),
        .groupSize(groupSize2), .occupancy(occupancy2)
    );

    batch_pipeline_unit #(.PIPELINE_STAGES(7)) dut7 (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady7), .batch(batch),
        .endTag(endTag), .flush(flush), .outValid(outValid7), .outReady(outReady),
        .outInstr(outInstr7), .outFmt(outFmt7), .outEndTag(outEndTag7), .doneBatches(doneBatches7),
        .groupSize(groupSize7), .occupancy(occupancy7)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    typedef struct {
        logic       inValid;
        logic [7:0] id;
        logic       endTag;
        logic       outReady;
        logic       expInReady;
        logic       expOutValid;
        logic [7:0] expOutId;
        logic       expOutEnd;
        logic       expDone;
        int         expOcc;
        int         expGroup;
    } vec_t;

    vec_t vecs [26];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Lane i: format = id[2:0]+i, instruction = {i, id}; metadata filler bits set to non-zero.
    function automatic logic [BATCH_WIDTH-1:0] mkBatch(input logic [7:0] id);
        logic [BATCH_WIDTH-1:0] b;
        b        = '0;
        b[0]     = 1'b1;
        b[15:13] = 3'b101;
        for (int i = 0; i < 4; i++) begin
            b[1 + i*3 +: 3]   = id[2:0] + 3'(i);
            b[16 + i*16 +: 16] = {8'(i), id};
        end
        return b;
    endfunction

    function automatic logic [63:0] expInstr(input logic [7:0] id);
        return {8'd3, id, 8'd2, id, 8'd1, id, 8'd0, id};
    endfunction

    function automatic logic [11:0] expFmt(input logic [7:0] id);
        return {id[2:0] + 3'd3, id[2:0] + 3'd2, id[2:0] + 3'd1, id[2:0]};
    endfunction

    function automatic vec_t v(input logic iv, input logic [7:0] id, input logic et, input logic ordy,
                               input logic eir, input logic eov, input logic [7:0] eid, input logic eend,
                               input logic edone, input int eocc, input int egrp);
        vec_t r;
        r.inValid = iv;  r.id = id;  r.endTag = et;  r.outReady = ordy;
        r.expInReady = eir;  r.expOutValid = eov;  r.expOutId = eid;  r.expOutEnd = eend;
        r.expDone = edone;  r.expOcc = eocc;  r.expGroup = egrp;
        return r;
    endfunction

    initial begin
        int pulses, firstK;
        int first2, first4, first7, done2, done4, done7;

        //                iv  id   et ord  ir ov oid  oe dn occ grp
        vecs[0]  = v(1, 8'h01, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0);
        vecs[1]  = v(1, 8'h02, 0, 1,  1, 0, 8'h00, 0, 0, 1, 0);
        vecs[2]  = v(1, 8'h03, 0, 1,  1, 0, 8'h00, 0, 0, 2, 0);
        vecs[3]  = v(1, 8'h04, 0, 1,  1, 0, 8'h00, 0, 0, 3, 0);
        vecs[4]  = v(1, 8'h05, 0, 1,  1, 1, 8'h01, 0, 0, 4, 0);
        vecs[5]  = v(1, 8'h06, 0, 1,  1, 1, 8'h02, 0, 0, 4, 0);
        vecs[6]  = v(1, 8'h07, 0, 1,  1, 1, 8'h03, 0, 0, 4, 0);
        vecs[7]  = v(1, 8'h08, 1, 1,  1, 1, 8'h04, 0, 0, 4, 0);
        vecs[8]  = v(0, 8'h00, 0, 1,  1, 1, 8'h05, 0, 0, 4, 0);
        vecs[9]  = v(0, 8'h00, 0, 1,  1, 1, 8'h06, 0, 0, 3, 0);
        vecs[10] = v(0, 8'h00, 0, 1,  1, 1, 8'h07, 0, 0, 2, 0);
        vecs[11] = v(0, 8'h00, 0, 1,  1, 1, 8'h08, 1, 0, 1, 0);
        vecs[12] = v(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 1, 0, 8);
        vecs[13] = v(1, 8'h09, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8);
        vecs[14] = v(1, 8'h0A, 0, 0,  1, 0, 8'h00, 0, 0, 1, 8);
        vecs[15] = v(1, 8'h0B, 0, 0,  1, 0, 8'h00, 0, 0, 2, 8);
        vecs[16] = v(1, 8'h0C, 0, 0,  1, 0, 8'h00, 0, 0, 3, 8);
        vecs[17] = v(1, 8'h0D, 0, 0,  0, 1, 8'h09, 0, 0, 4, 8);
        vecs[18] = v(1, 8'h0D, 0, 0,  0, 1, 8'h09, 0, 0, 4, 8);
        vecs[19] = v(1, 8'h0D, 0, 1,  1, 1, 8'h09, 0, 0, 4, 8);
        vecs[20] = v(1, 8'h0E, 0, 1,  1, 1, 8'h0A, 0, 0, 4, 8);
        vecs[21] = v(0, 8'h00, 0, 1,  1, 1, 8'h0B, 0, 0, 4, 8);
        vecs[22] = v(0, 8'h00, 0, 1,  1, 1, 8'h0C, 0, 0, 3, 8);
        vecs[23] = v(0, 8'h00, 0, 1,  1, 1, 8'h0D, 0, 0, 2, 8);
        vecs[24] = v(0, 8'h00, 0, 1,  1, 1, 8'h0E, 0, 0, 1, 8);
        vecs[25] = v(0, 8'h00, 0, 1,  1, 0, 8'h00, 0, 0, 0, 8);

        reset = 1'b0; inValid = 1'b0; batch = '0; endTag = 1'b0; flush = 1'b0; outReady = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check("reset inReady",     64'(inReady),     64'(1));
        check("reset outValid",    64'(outValid),    64'(0));
        check("reset occupancy",   64'(occupancy),   64'(0));
        check("reset doneBatches", 64'(doneBatches), 64'(0));
        check("reset groupSize",   64'(groupSize),   64'(0));
        @(negedge clock);
        reset = 1'b1;

        // Reset mid-stream with three batches in flight
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            inValid = 1'b1; batch = mkBatch(8'(8'h60 + i)); endTag = 1'b0; outReady = 1'b0;
        end
        @(negedge clock);
        inValid = 1'b0;
        #1;
        check("midreset pre occupancy", 64'(occupancy), 64'(3));
        @(negedge clock);
        #1;
        check("midreset pre outValid", 64'(outValid), 64'(1));
        check("midreset pre outInstr", outInstr, expInstr(8'h60));
        reset = 1'b0;
        #1;
        check("midreset outValid",  64'(outValid),  64'(0));
        check("midreset occupancy", 64'(occupancy), 64'(0));
        check("midreset inReady",   64'(inReady),   64'(1));
        @(negedge clock);
        reset = 1'b1;

        // Streaming and stall vectors
        for (int r = 0; r < 26; r++) begin
            @(negedge clock);
            inValid  = vecs[r].inValid;
            batch    = mkBatch(vecs[r].id);
            endTag   = vecs[r].endTag;
            outReady = vecs[r].outReady;
            #1;
            check($sformatf("vec%0d inReady", r),     64'(inReady),     64'(vecs[r].expInReady));
            check($sformatf("vec%0d outValid", r),    64'(outValid),    64'(vecs[r].expOutValid));
            check($sformatf("vec%0d occupancy", r),   64'(occupancy),   64'(vecs[r].expOcc));
            check($sformatf("vec%0d doneBatches", r), 64'(doneBatches), 64'(vecs[r].expDone));
            check($sformatf("vec%0d groupSize", r),   64'(groupSize),   64'(vecs[r].expGroup));
            if (vecs[r].expOutValid) begin
                check($sformatf("vec%0d outInstr", r),  outInstr,        expInstr(vecs[r].expOutId));
                check($sformatf("vec%0d outFmt", r),    64'(outFmt),     64'(expFmt(vecs[r].expOutId)));
                check($sformatf("vec%0d outEndTag", r), 64'(outEndTag),  64'(vecs[r].expOutEnd));
            end
        end

        // Bubbles: accept on alternate cycles while the output is stalled
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            outReady = 1'b0;
            inValid  = (i % 2 == 0);
            batch    = mkBatch(8'(8'hA5 + i / 2));
            endTag   = 1'b0;
            #1;
            if (i % 2 == 0) check($sformatf("bubble accept %0d", i / 2), 64'(inReady), 64'(1));
        end
        @(negedge clock);
        inValid = 1'b0;
        #1;
        check("bubble occupancy",  64'(occupancy),      64'(4));
        check("bubble inReady",    64'(inReady),        64'(0));
        check("bubble lane0 instr", 64'(outInstr[15:0]), 64'(16'h00A5));
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            outReady = 1'b1;
            #1;
            check($sformatf("bubble drain%0d outValid", i), 64'(outValid), 64'(1));
            check($sformatf("bubble drain%0d outInstr", i), outInstr, expInstr(8'(8'hA5 + i)));
            check($sformatf("bubble drain%0d outFmt", i),   64'(outFmt), 64'(expFmt(8'(8'hA5 + i))));
        end
        @(negedge clock);
        #1;
        check("bubble empty occupancy", 64'(occupancy), 64'(0));

        // Flush with an endTag batch at the output
        @(negedge clock);
        outReady = 1'b0; inValid = 1'b1; batch = mkBatch(8'h31); endTag = 1'b1;
        @(negedge clock);
        batch = mkBatch(8'h32); endTag = 1'b0;
        @(negedge clock);
        batch = mkBatch(8'h33);
        @(negedge clock);
        inValid = 1'b0;
        #1;
        check("flush pre occupancy", 64'(occupancy), 64'(3));
        @(negedge clock);
        flush = 1'b1; outReady = 1'b1; inValid = 1'b1; batch = mkBatch(8'h34); endTag = 1'b1;
        #1;
        check("flush outValid forced", 64'(outValid),  64'(0));
        check("flush inReady",         64'(inReady),   64'(0));
        check("flush endTag at output", 64'(outEndTag), 64'(1));
        @(negedge clock);
        flush = 1'b0; inValid = 1'b0; endTag = 1'b0;
        #1;
        check("post-flush occupancy",   64'(occupancy),   64'(0));
        check("post-flush outValid",    64'(outValid),    64'(0));
        check("post-flush doneBatches", 64'(doneBatches), 64'(0));
        check("post-flush groupSize",   64'(groupSize),   64'(8));
        @(negedge clock);
        #1;
        check("post-flush doneBatches 2", 64'(doneBatches), 64'(0));

        // Group counter restarts from zero after the flush
        pulses = 0;
        firstK = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            outReady = 1'b1;
            inValid  = (k == 0);
            endTag   = (k == 0);
            batch    = mkBatch(8'h40);
            #1;
            if (doneBatches) pulses++;
            if (outValid && firstK < 0) firstK = k;
        end
        check("relaunch latency",   64'(firstK),    64'(4));
        check("relaunch pulses",    64'(pulses),    64'(1));
        check("relaunch groupSize", 64'(groupSize), 64'(1));

        // Depth variants: 2, 4 and 7 stages fed the same three-batch group
        @(negedge clock);
        reset = 1'b0; inValid = 1'b0; endTag = 1'b0;
        #1;
        check("N2 reset occupancy", 64'(occupancy2), 64'(0));
        check("N7 reset occupancy", 64'(occupancy7), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        first2 = -1; first4 = -1; first7 = -1;
        done2 = 0; done4 = 0; done7 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            outReady = 1'b1;
            inValid  = (k < 3);
            endTag   = (k == 2);
            batch    = mkBatch(8'(8'h51 + k));
            #1;
            if (k < 3) begin
                check($sformatf("N2 inReady k%0d", k), 64'(inReady2), 64'(1));
                check($sformatf("N4 inReady k%0d", k), 64'(inReady),  64'(1));
                check($sformatf("N7 inReady k%0d", k), 64'(inReady7), 64'(1));
            end
            if (outValid2 && first2 < 0) begin
                first2 = k;
                check("N2 first outInstr",  outInstr2,       expInstr(8'h51));
                check("N2 first outFmt",    64'(outFmt2),    64'(expFmt(8'h51)));
                check("N2 first outEndTag", 64'(outEndTag2), 64'(0));
            end
            if (outValid && first4 < 0) first4 = k;
            if (outValid7 && first7 < 0) begin
                first7 = k;
                check("N7 first outInstr",  outInstr7,       expInstr(8'h51));
                check("N7 first outFmt",    64'(outFmt7),    64'(expFmt(8'h51)));
                check("N7 first outEndTag", 64'(outEndTag7), 64'(0));
            end
            if (doneBatches2) done2++;
            if (doneBatches)  done4++;
            if (doneBatches7) done7++;
        end
        check("N2 latency",   64'(first2 - 1), 64'(1));
        check("N4 latency",   64'(first4 - 1), 64'(3));
        check("N7 latency",   64'(first7 - 1), 64'(6));
        check("N2 pulses",    64'(done2),      64'(1));
        check("N4 pulses",    64'(done4),      64'(1));
        check("N7 pulses",    64'(done7),      64'(1));
        check("N2 groupSize", 64'(groupSize2), 64'(3));
        check("N4 groupSize", 64'(groupSize),  64'(3));
        check("N7 groupSize", 64'(groupSize7), 64'(3));
        check("N2 drained",   64'(occupancy2), 64'(0));
        check("N7 drained",   64'(occupancy7), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
